// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//
// Purpose:
//   Shares the single register-file write port between the in-order pipeline
//   write-back stream and a long-latency unit (LU, e.g. multi-cycle mul/div).
//   LU results are accepted through a valid/ready handshake into a 2-entry
//   FIFO and are drained only in cycles where the pipeline does not write.
//   A pipeline write to a register kills (marks dead) any older buffered LU
//   result for the same register, so the regfile always ends up with the
//   youngest value. A busy-check port lets the hazard unit ask whether a
//   register still has a live buffered LU write pending.
//
// Optional feature:
//   `define WB_ARB_FAIR_EN to compile in the anti-starvation logic. A buffered
//   head entry that has waited STARVE_LIMIT cycles raises a registered force
//   flag that stalls the pipeline for one forced pop. Without the macro the
//   pipeline always has priority and pipe_stall_o is tied low.
//
// Parameters:
//   XLEN          data width
//   STARVE_LIMIT  waiting cycles before a forced drain (fairness build only)
//
// Ports:
//   clk           clock
//   reset         asynchronous, active-low reset
//   pipe_we_i     pipeline write request (rd 0 counts as idle)
//   pipe_rd_i     pipeline destination register
//   pipe_wdata_i  pipeline write data
//   lu_valid_i    LU result valid
//   lu_rd_i       LU destination register (rd 0 accepted and discarded)
//   lu_wdata_i    LU result data
//   lu_ready_o    FIFO not full (combinational, no pop look-ahead)
//   chk_rd_i      register queried by the hazard unit
//   chk_busy_o    chk_rd_i has a live buffered LU write (combinational)
//   pipe_stall_o  pipeline must hold its request (fairness build only)
//   rf_we_o       regfile write enable (registered)
//   rf_waddr_o    regfile write address (registered)
//   rf_wdata_o    regfile write data (registered)
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pipe_we_i,
  input  logic [4:0]      pipe_rd_i,
  input  logic [XLEN-1:0] pipe_wdata_i,
  input  logic            lu_valid_i,
  input  logic [4:0]      lu_rd_i,
  input  logic [XLEN-1:0] lu_wdata_i,
  output logic            lu_ready_o,
  input  logic [4:0]      chk_rd_i,
  output logic            chk_busy_o,
  output logic            pipe_stall_o,
  output logic            rf_we_o,
  output logic [4:0]      rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o
);

  // A zero limit would force a drain before any waiting happened.
  if (STARVE_LIMIT == 0) begin : gLimitCheck
    $error("wb_port_arbiter: STARVE_LIMIT must be at least 1");
  end

  // FIFO storage: two slots addressed by single-bit read/write pointers.
  logic [4:0]      entRd_q    [2];
  logic [4:0]      entRd_d    [2];
  logic [XLEN-1:0] entData_q  [2];
  logic [XLEN-1:0] entData_d  [2];
  logic [1:0]      entValid_q, entValid_d;
  logic [1:0]      entLive_q,  entLive_d;
  logic            rdPtr_q,    rdPtr_d;
  logic            wrPtr_q,    wrPtr_d;

  // Registered write port.
  logic            rfWe_q,    rfWe_d;
  logic [4:0]      rfWaddr_q, rfWaddr_d;
  logic [XLEN-1:0] rfWdata_q, rfWdata_d;

  // Per-cycle arbitration decisions.
  logic pipeReq;
  logic fifoEmpty;
  logic fifoFull;
  logic luPush;
  logic forceDrain;
  logic grantPipe;
  logic popHead;
  logic headLive;
  logic busyHit;

  assign pipeReq    = pipe_we_i & (pipe_rd_i != 5'd0);
  assign fifoEmpty  = (entValid_q == 2'b00);
  assign fifoFull   = &entValid_q;
  assign lu_ready_o = ~fifoFull;

  // An accepted rd 0 result completes the handshake but is never stored.
  assign luPush    = lu_valid_i & ~fifoFull & (lu_rd_i != 5'd0);
  assign grantPipe = pipeReq & ~forceDrain;
  assign popHead   = ~grantPipe & ~fifoEmpty;
  assign headLive  = entLive_q[rdPtr_q];

  // Busy check looks only at entries already stored, never at the arrival.
  always_comb begin
    busyHit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (entValid_q[i] && entLive_q[i] && (entRd_q[i] == chk_rd_i)) begin
        busyHit = 1'b1;
      end
    end
  end

  assign chk_busy_o = busyHit & (chk_rd_i != 5'd0);

  // FIFO next state: pop, ordering kill, then push into the free slot.
  always_comb begin
    entRd_d    = entRd_q;
    entData_d  = entData_q;
    entValid_d = entValid_q;
    entLive_d  = entLive_q;
    rdPtr_d    = rdPtr_q;
    wrPtr_d    = wrPtr_q;

    if (popHead) begin
      entValid_d[rdPtr_q] = 1'b0;
      entLive_d[rdPtr_q]  = 1'b0;
      rdPtr_d             = ~rdPtr_q;
    end

    // The pipe write is younger than anything already buffered for its rd.
    if (grantPipe) begin
      for (int i = 0; i < 2; i++) begin
        if (entValid_q[i] && (entRd_q[i] == pipe_rd_i)) begin
          entLive_d[i] = 1'b0;
        end
      end
    end

    // The push slot is empty whenever the FIFO is not full, so it never
    // collides with the kill above; a same-cycle LU result stays live.
    if (luPush) begin
      entValid_d[wrPtr_q] = 1'b1;
      entLive_d[wrPtr_q]  = 1'b1;
      entRd_d[wrPtr_q]    = lu_rd_i;
      entData_d[wrPtr_q]  = lu_wdata_i;
      wrPtr_d             = ~wrPtr_q;
    end
  end

  // Write-port next state; address and data hold when nothing is written.
  always_comb begin
    rfWe_d    = 1'b0;
    rfWaddr_d = rfWaddr_q;
    rfWdata_d = rfWdata_q;
    if (grantPipe) begin
      rfWe_d    = 1'b1;
      rfWaddr_d = pipe_rd_i;
      rfWdata_d = pipe_wdata_i;
    end else if (popHead && headLive) begin
      rfWe_d    = 1'b1;
      rfWaddr_d = entRd_q[rdPtr_q];
      rfWdata_d = entData_q[rdPtr_q];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        entRd_q[i]   <= 5'd0;
        entData_q[i] <= '0;
      end
      entValid_q <= 2'b00;
      entLive_q  <= 2'b00;
      rdPtr_q    <= 1'b0;
      wrPtr_q    <= 1'b0;
      rfWe_q     <= 1'b0;
      rfWaddr_q  <= 5'd0;
      rfWdata_q  <= '0;
    end else begin
      entRd_q    <= entRd_d;
      entData_q  <= entData_d;
      entValid_q <= entValid_d;
      entLive_q  <= entLive_d;
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      rfWe_q     <= rfWe_d;
      rfWaddr_q  <= rfWaddr_d;
      rfWdata_q  <= rfWdata_d;
    end
  end

  assign rf_we_o    = rfWe_q;
  assign rf_waddr_o = rfWaddr_q;
  assign rf_wdata_o = rfWdata_q;

`ifdef WB_ARB_FAIR_EN
  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

  logic [CntW-1:0] starveCnt_q, starveCnt_d;
  logic            forceDrain_q, forceDrain_d;

  // Count cycles the head sits unpopped; the flag rises on the same edge the
  // count reaches the limit and both clear when the head finally pops, so
  // each trigger buys exactly one forced pop.
  always_comb begin
    starveCnt_d  = starveCnt_q;
    forceDrain_d = forceDrain_q;
    if (popHead) begin
      starveCnt_d  = '0;
      forceDrain_d = 1'b0;
    end else if (!fifoEmpty) begin
      if (starveCnt_q < CntW'(STARVE_LIMIT)) begin
        starveCnt_d = starveCnt_q + 1'b1;
      end
      if (starveCnt_d == CntW'(STARVE_LIMIT)) begin
        forceDrain_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starveCnt_q  <= '0;
      forceDrain_q <= 1'b0;
    end else begin
      starveCnt_q  <= starveCnt_d;
      forceDrain_q <= forceDrain_d;
    end
  end

  assign forceDrain   = forceDrain_q;
  assign pipe_stall_o = forceDrain_q;
`else
  assign forceDrain   = 1'b0;
  assign pipe_stall_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_port_arbiter
//
// Directed bench for wb_port_arbiter. Inputs change one time unit after each
// rising edge; registered outputs are sampled right after the edge and
// combinational outputs one time unit after the inputs settle. Expected values
// are hand-computed constants. Compile with WB_ARB_FAIR_EN defined to exercise
// the forced-drain path (STARVE_LIMIT = 4).
// -----------------------------------------------------------------------------
module tb_wb_port_arbiter;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic            pipeWe;
  logic [4:0]      pipeRd;
  logic [XLEN-1:0] pipeWdata;
  logic            luValid;
  logic [4:0]      luRd;
  logic [XLEN-1:0] luWdata;
  logic            luReady;
  logic [4:0]      chkRd;
  logic            chkBusy;
  logic            pipeStall;
  logic            rfWe;
  logic [4:0]      rfWaddr;
  logic [XLEN-1:0] rfWdata;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .XLEN         (XLEN),
    .STARVE_LIMIT (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pipe_we_i    (pipeWe),
    .pipe_rd_i    (pipeRd),
    .pipe_wdata_i (pipeWdata),
    .lu_valid_i   (luValid),
    .lu_rd_i      (luRd),
    .lu_wdata_i   (luWdata),
    .lu_ready_o   (luReady),
    .chk_rd_i     (chkRd),
    .chk_busy_o   (chkBusy),
    .pipe_stall_o (pipeStall),
    .rf_we_o      (rfWe),
    .rf_waddr_o   (rfWaddr),
    .rf_wdata_o   (rfWdata)
  );

  task automatic applyStimulus(input logic pwe, input logic [4:0] prd,
                               input logic [63:0] pdata, input logic lv,
                               input logic [4:0] lrd, input logic [63:0] ldata,
                               input logic [4:0] crd);
    pipeWe    = pwe;
    pipeRd    = prd;
    pipeWdata = pdata;
    luValid   = lv;
    luRd      = lrd;
    luWdata   = ldata;
    chkRd     = crd;
    #1;
  endtask

  task automatic stepClock;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkRf(input string tag, input logic we,
                         input logic [4:0] addr, input logic [63:0] data);
    checkOutput({tag, ".we"},    64'(rfWe),    64'(we));
    checkOutput({tag, ".waddr"}, 64'(rfWaddr), 64'(addr));
    checkOutput({tag, ".wdata"}, rfWdata,      data);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before end of test");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    $display("[TB] starting wb_port_arbiter directed test");
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #10;
    checkRf("reset", 0, 0, 0);
    checkOutput("reset.luReady",   64'(luReady),   64'd1);
    checkOutput("reset.chkBusy",   64'(chkBusy),   64'd0);
    checkOutput("reset.pipeStall", 64'(pipeStall), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    stepClock();

    // Single pipe write, then the port goes idle with address/data held.
    applyStimulus(1, 5, 64'h11, 0, 0, 0, 0);
    stepClock();
    checkRf("pipe1", 1, 5, 64'h11);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    stepClock();
    checkRf("pipe1Idle", 0, 5, 64'h11);

    // LU drain: accepted in N, popped in N+1, visible in N+2.
    applyStimulus(0, 0, 0, 1, 7, 64'hAA, 7);
    checkOutput("luArrive.luReady", 64'(luReady), 64'd1);
    checkOutput("luArrive.chkBusy", 64'(chkBusy), 64'd0);
    stepClock();
    applyStimulus(0, 0, 0, 0, 0, 0, 7);
    checkRf("luBuffered", 0, 5, 64'h11);
    checkOutput("luBuffered.chkBusy", 64'(chkBusy), 64'd1);
    checkOutput("luBuffered.luReady", 64'(luReady), 64'd1);
    stepClock();
    checkRf("luDrain", 1, 7, 64'hAA);
    checkOutput("luDrain.chkBusy", 64'(chkBusy), 64'd0);
    stepClock();
    checkRf("luIdle", 0, 7, 64'hAA);

    // FIFO full while the pipe writes x9 for four cycles.
    applyStimulus(1, 9, 64'h901, 1, 3, 64'h33, 3);
    checkOutput("full1.luReady", 64'(luReady), 64'd1);
    stepClock();
    checkRf("full2", 1, 9, 64'h901);
    applyStimulus(1, 9, 64'h902, 1, 4, 64'h44, 3);
    checkOutput("full2.luReady", 64'(luReady), 64'd1);
    checkOutput("full2.chkBusy", 64'(chkBusy), 64'd1);
    stepClock();
    checkRf("full3", 1, 9, 64'h902);
    applyStimulus(1, 9, 64'h903, 1, 8, 64'h88, 4);
    checkOutput("full3.luReady", 64'(luReady), 64'd0);
    checkOutput("full3.chkBusy", 64'(chkBusy), 64'd1);
    stepClock();
    checkRf("full4", 1, 9, 64'h903);
    applyStimulus(1, 9, 64'h904, 1, 8, 64'h88, 4);
    checkOutput("full4.luReady", 64'(luReady), 64'd0);
    stepClock();
    checkRf("full5", 1, 9, 64'h904);
    // Popping this cycle does not reopen the FIFO early.
    applyStimulus(0, 0, 0, 1, 8, 64'h88, 8);
    checkOutput("full5.luReady", 64'(luReady), 64'd0);
    checkOutput("full5.chkBusy", 64'(chkBusy), 64'd0);
    stepClock();
    checkRf("full6", 1, 3, 64'h33);
    applyStimulus(0, 0, 0, 1, 8, 64'h88, 8);
    checkOutput("full6.luReady", 64'(luReady), 64'd1);
    checkOutput("full6.chkBusy", 64'(chkBusy), 64'd0);
    stepClock();
    checkRf("full7", 1, 4, 64'h44);
    applyStimulus(0, 0, 0, 0, 0, 0, 8);
    checkOutput("full7.chkBusy", 64'(chkBusy), 64'd1);
    stepClock();
    checkRf("full8", 1, 8, 64'h88);
    checkOutput("full8.chkBusy", 64'(chkBusy), 64'd0);
    stepClock();
    checkRf("full9", 0, 8, 64'h88);

    // Ordering kill: buffered x6=0x1 is overtaken by pipe x6=0x2.
    applyStimulus(0, 0, 0, 1, 6, 64'h1, 6);
    stepClock();
    checkRf("kill2", 0, 8, 64'h88);
    applyStimulus(1, 6, 64'h2, 0, 0, 0, 6);
    checkOutput("kill2.chkBusy", 64'(chkBusy), 64'd1);
    stepClock();
    checkRf("kill3", 1, 6, 64'h2);
    applyStimulus(0, 0, 0, 0, 0, 0, 6);
    checkOutput("kill3.chkBusy", 64'(chkBusy), 64'd0);
    stepClock();
    checkRf("kill4", 0, 6, 64'h2);
    checkOutput("kill4.luReady", 64'(luReady), 64'd1);

    // Same-cycle LU result for the pipe's rd is younger and stays live.
    applyStimulus(1, 10, 64'hA1, 1, 10, 64'hA2, 10);
    checkOutput("young1.chkBusy", 64'(chkBusy), 64'd0);
    stepClock();
    checkRf("young2", 1, 10, 64'hA1);
    applyStimulus(0, 0, 0, 0, 0, 0, 10);
    checkOutput("young2.chkBusy", 64'(chkBusy), 64'd1);
    stepClock();
    checkRf("young3", 1, 10, 64'hA2);
    checkOutput("young3.chkBusy", 64'(chkBusy), 64'd0);

    // x0 handling on both requesters.
    applyStimulus(1, 0, 64'h66, 1, 0, 64'h55, 0);
    checkOutput("x0.luReady", 64'(luReady), 64'd1);
    checkOutput("x0.chkBusy", 64'(chkBusy), 64'd0);
    stepClock();
    checkRf("x0a", 0, 10, 64'hA2);
    checkOutput("x0a.luReady", 64'(luReady), 64'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    stepClock();
    checkRf("x0b", 0, 10, 64'hA2);

    // Starvation: one buffered x12 with the pipe writing x13 continuously.
    applyStimulus(1, 13, 64'hD0, 1, 12, 64'hC, 12);
    stepClock();
    applyStimulus(1, 13, 64'hD0, 0, 0, 0, 12);
`ifdef WB_ARB_FAIR_EN
    for (int k = 1; k <= 4; k++) begin
      checkOutput($sformatf("fairWait%0d.pipeStall", k), 64'(pipeStall), 64'd0);
      checkOutput($sformatf("fairWait%0d.chkBusy", k), 64'(chkBusy), 64'd1);
      checkRf($sformatf("fairWait%0d", k), 1, 13, 64'hD0);
      stepClock();
    end
    checkOutput("fairForce.pipeStall", 64'(pipeStall), 64'd1);
    checkRf("fairForce", 1, 13, 64'hD0);
    stepClock();
    checkRf("fairLand", 1, 12, 64'hC);
    checkOutput("fairLand.pipeStall", 64'(pipeStall), 64'd0);
    checkOutput("fairLand.chkBusy", 64'(chkBusy), 64'd0);
    stepClock();
    checkRf("fairResume", 1, 13, 64'hD0);
`else
    for (int k = 1; k <= 8; k++) begin
      checkOutput($sformatf("prioWait%0d.pipeStall", k), 64'(pipeStall), 64'd0);
      checkOutput($sformatf("prioWait%0d.chkBusy", k), 64'(chkBusy), 64'd1);
      checkRf($sformatf("prioWait%0d", k), 1, 13, 64'hD0);
      stepClock();
    end
`endif

    // Mid-operation reset drops buffered results immediately.
    applyStimulus(1, 13, 64'hD0, 1, 14, 64'hE, 14);
    stepClock();
    applyStimulus(1, 13, 64'hD0, 0, 0, 0, 14);
    checkOutput("preReset.chkBusy", 64'(chkBusy), 64'd1);
    reset = 1'b0;
    #1;
    checkRf("midReset", 0, 0, 0);
    checkOutput("midReset.luReady",   64'(luReady),   64'd1);
    checkOutput("midReset.chkBusy",   64'(chkBusy),   64'd0);
    checkOutput("midReset.pipeStall", 64'(pipeStall), 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 14);
    @(negedge clk);
    reset = 1'b1;
    stepClock();
    checkRf("postReset", 0, 0, 0);
    checkOutput("postReset.chkBusy", 64'(chkBusy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

- Shares the single register-file write port between two requesters:
  - the in-order pipeline write-back stream;
  - a long-latency unit (LU), e.g. a multi-cycle mul/div, through a valid/ready handshake.
- LU results are buffered in a 2-entry FIFO and drained only in cycles the pipeline does not write.
- Provides register-order protection, a busy-check port for the hazard unit and an optional anti-starvation stall.
- Sits between WB stage / LU and the regfile write port.

## Interface
- XLEN, 64, data width
- STARVE_LIMIT, 4, cycles a buffered LU entry may wait before forcing a stall (only with WB_ARB_FAIR_EN)

- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- pipe_we  in  1  pipeline write request
- pipe_rd  in  5  pipeline destination register
- pipe_wdata  in  XLEN  pipeline write data
- lu_valid  in  1  LU result valid
- lu_rd  in  5  LU destination register
- lu_wdata  in  XLEN  LU result data
- lu_ready  out  1  arbiter can accept LU result
- chk_rd  in  5  register queried by hazard unit
- chk_busy  out  1  chk_rd has a live buffered LU write
- pipe_stall  out  1  pipeline must hold (fairness)
- rf_we  out  1  regfile write enable (registered)
- rf_waddr  out  5  regfile write address (registered)
- rf_wdata  out  XLEN  regfile write data (registered)

## Operation
**Requests and FIFO**
- Pipe request is live when pipe_we=1 and pipe_rd!=0.
  - pipe_we with rd 0 is treated as idle.
- FIFO: 2 entries {rd, data, live}. lu_ready = FIFO not full (combinational).
- LU accept when lu_valid & lu_ready.
  - lu_rd=0 is accepted and discarded, never enqueued.
- Push and pop in the same cycle are legal.
  - A full FIFO that pops in the cycle still deasserts lu_ready; it does not look ahead.

**Grant per cycle**
- Grant pipe if the pipe request is live and no forced drain is active.
- Otherwise, pop the FIFO head if the FIFO is non-empty.
- Otherwise, idle.

**Register-port update (each edge)**
- Pipe granted: rf_we=1, rf_waddr=pipe_rd, rf_wdata=pipe_wdata.
- Head popped and live: rf_we=1 with the head's rd/data.
- Head popped and dead: rf_we=0; the entry is dropped.
- Idle: rf_we=0; rf_waddr and rf_wdata hold their previous values.

**Ordering rule**
- On a pipe grant, every FIFO entry already present with rd == pipe_rd has live cleared. The pipe write is younger.
- An LU result accepted in the same cycle is younger than the pipe write. It is enqueued live.

**Busy check**
- chk_busy = (chk_rd != 0) & any live FIFO entry with matching rd.
- Combinational; does not include the LU entry arriving this cycle.

**Reset**
- Asynchronous reset, asserted mid-operation, empties the FIFO.
- Buffered results are lost.

## Timing
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, FIFO empty, starvation counter 0.
  - Hence lu_ready=1, chk_busy=0, pipe_stall=0.
- Pipe write latency: request in cycle N → rf_we visible in cycle N+1.
- LU write latency, minimum: accepted in cycle N → popped no earlier than N+1 → rf_we visible in N+2.
- Throughput: exactly one regfile write per cycle maximum. The pipeline is never delayed unless fairness is compiled in.

## Configuration
- WB_ARB_FAIR_EN defined:
  - Counter increments each cycle the FIFO is non-empty and the head is not popped.
  - When the count reaches STARVE_LIMIT, a registered force flag sets.
  - While the flag is set: pipe_stall=1 and the head is granted even if the pipe request is live.
  - The pipeline must hold pipe_we/pipe_rd/pipe_wdata stable during the stall.
  - The flag and counter clear on the cycle the head pops. One forced pop per trigger.
- WB_ARB_FAIR_EN undefined:
  - No counter and no flag.
  - pipe_stall is tied to 0; the pipe always has priority.

## Test plan
- **Idle, single pipe write:** after reset, pipe_we=1, rd=5, data=0x11 in one cycle → next cycle rf_we=1, waddr=5, wdata=0x11; following cycle rf_we=0.
- **LU drain:** LU pushes rd=7, data=0xAA while pipe_we=0 → lu_ready stays 1; write to x7 appears two cycles later; chk_rd=7 gives chk_busy=1 only while buffered.
- **FIFO full:** LU pushes rd=3 and rd=4 while pipe_we=1 (rd=9) for four cycles → lu_ready=0 after two accepts; x9 written each cycle; x3 then x4 written once the pipe goes idle.
- **Ordering kill:** buffer LU rd=6, 0x1; pipe writes rd=6, 0x2 → only 0x2 reaches x6; later pop of the dead entry gives rf_we=0; chk_busy for 6 drops after the pipe grant.
- **x0 handling:** LU rd=0 valid and pipe_we with rd=0 → LU accepted (lu_ready=1), FIFO stays empty, rf_we never asserts.
- **Fairness (macro on, STARVE_LIMIT=4):** one buffered LU entry with pipe_we=1 continuously → pipe_stall=1 in the cycle after the 4th waiting cycle; LU write lands; pipe_stall drops the next cycle. Macro off: pipe_stall=0 throughout and the entry waits indefinitely.
